// File: rtl/pll_reset_seq_pkg.sv
// pll_seq_pkg: shared definitions for the PLL reset/lock sequencer.
//   state_t   - FSM state encoding, also exported on the debug state port.
//   DEF_*     - default parameter values for pll_reset_seq.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  localparam int DEF_NUM_DOMAINS  = 4;
  localparam int DEF_RST_HOLD     = 16;
  localparam int DEF_LOCK_TIMEOUT = 50000;
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_STAGGER      = 8;
  localparam int DEF_LOSS_FILTER  = 4;
  localparam int DEF_MAX_RETRIES  = 3;

endpackage

// File: rtl/pll_reset_seq_sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser, async active-low reset to 0.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   i_d   - asynchronous input
//   o_q   - synchronised output (two destination-clock cycles of latency)
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: reset/lock sequencer for the core PLL, refclk domain.
// Pulses the PLL reset, waits for a debounced lock (with timeout and bounded
// retries), then releases the downstream domain resets one at a time. Lock
// loss or a software request tears everything back down.
// Ports:
//   clk          - refclk
//   rst_n        - asynchronous active-low reset
//   pll_locked   - PLL lock indicator (asynchronous, synchronised here)
//   req_reset    - level request to re-sequence from scratch
//   pll_rst      - PLL reset, active high
//   domain_rst_n - per-domain resets, active low, released in index order
//   ready        - all domains released
//   fail         - retries exhausted
//   retry_cnt    - failed attempts since last success/request (saturating)
//   state        - current FSM state (debug)
//
// state      | meaning
// -----------+--------------------------------------------------------------
// RESET      | pll_rst high for RST_HOLD cycles, all domains held
// WAIT_LOCK  | pll_rst low, waiting for synchronised lock; timeout running
// STABLE     | counting consecutive locked cycles; timeout still running
// RELEASE    | releasing domain resets every STAGGER cycles
// RUN        | all domains released, ready high
// FAIL       | retries exhausted; waits for req_reset or rst_n
//
// NUM_DOMAINS must be at least 2; retry_cnt is 2 bits so MAX_RETRIES <= 3.
module pll_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS  = DEF_NUM_DOMAINS,
  parameter int RST_HOLD     = DEF_RST_HOLD,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int STAGGER      = DEF_STAGGER,
  parameter int LOSS_FILTER  = DEF_LOSS_FILTER,
  parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic                   req_reset,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic                   fail,
  output logic [1:0]             retry_cnt,
  output logic [2:0]             state
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE + 1);
  localparam int STAG_W = $clog2(STAGGER + 1);
  localparam int LOSS_W = $clog2(LOSS_FILTER + 1);

  // Each counter holds "cycles already spent"; the terminal compare is
  // against N-1 so that the N-th cycle is the one that acts.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE - 1);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_FILTER - 1);
  localparam logic [1:0]        RETRY_MAX = 2'(MAX_RETRIES);

  logic                   w_lock_s;
  logic                   w_timeout;
  logic                   w_loss_trip;
  logic [1:0]             w_retry_inc;
  logic [NUM_DOMAINS-1:0] w_dom_shift;

  state_t                 r_state;
  logic                   r_pll_rst;
  logic [NUM_DOMAINS-1:0] r_dom;
  logic                   r_ready;
  logic                   r_fail;
  logic [1:0]             r_retry;
  logic [HOLD_W-1:0]      r_hold;
  logic [TO_W-1:0]        r_to;
  logic [STAB_W-1:0]      r_stab;
  logic [STAG_W-1:0]      r_stag;
  logic [LOSS_W-1:0]      r_loss;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (pll_locked),
    .o_q   (w_lock_s)
  );

  assign w_timeout   = (r_to == TO_LAST);
  assign w_loss_trip = !w_lock_s && (r_loss == LOSS_LAST);
  assign w_retry_inc = (r_retry == RETRY_MAX) ? r_retry : r_retry + 2'd1;
  // Releasing by shifting ones in from bit 0 keeps release in index order
  // and makes an already-released domain impossible to re-assert here.
  assign w_dom_shift = {r_dom[NUM_DOMAINS-2:0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RESET;
      r_pll_rst <= 1'b1;
      r_dom     <= '0;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
      r_retry   <= '0;
      r_hold    <= '0;
      r_to      <= '0;
      r_stab    <= '0;
      r_stag    <= '0;
      r_loss    <= '0;
    end else if (req_reset) begin
      // Held request parks in RESET with the hold count pinned at 0, so the
      // RST_HOLD window starts only once the request drops.
      r_state   <= ST_RESET;
      r_pll_rst <= 1'b1;
      r_dom     <= '0;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
      r_retry   <= '0;
      r_hold    <= '0;
      r_to      <= '0;
      r_stab    <= '0;
      r_stag    <= '0;
      r_loss    <= '0;
    end else begin
      case (r_state)
        ST_RESET: begin
          r_dom   <= '0;
          r_ready <= 1'b0;
          if (r_hold == HOLD_LAST) begin
            r_state   <= ST_WAIT_LOCK;
            r_pll_rst <= 1'b0;
            r_hold    <= '0;
            r_to      <= '0;
            r_stab    <= '0;
          end else begin
            r_pll_rst <= 1'b1;
            r_hold    <= r_hold + 1'b1;
          end
        end

        ST_WAIT_LOCK, ST_STABLE: begin
          if (w_timeout) begin
            r_retry <= w_retry_inc;
            r_to    <= '0;
            r_stab  <= '0;
            r_hold  <= '0;
            if (w_retry_inc == RETRY_MAX) begin
              r_state   <= ST_FAIL;
              r_fail    <= 1'b1;
              r_pll_rst <= 1'b0;
            end else begin
              r_state   <= ST_RESET;
              r_pll_rst <= 1'b1;
            end
          end else begin
            // Timeout budget spans both states; a dropout in STABLE
            // does not buy a fresh window.
            r_to <= r_to + 1'b1;
            if (r_state == ST_WAIT_LOCK) begin
              r_stab <= '0;
              if (w_lock_s) r_state <= ST_STABLE;
            end else if (!w_lock_s) begin
              r_state <= ST_WAIT_LOCK;
              r_stab  <= '0;
            end else if (r_stab == STAB_LAST) begin
              r_state <= ST_RELEASE;
              r_dom   <= w_dom_shift;
              r_stab  <= '0;
              r_stag  <= '0;
              r_loss  <= '0;
            end else begin
              r_stab <= r_stab + 1'b1;
            end
          end
        end

        ST_RELEASE, ST_RUN: begin
          if (w_loss_trip) begin
            r_state   <= ST_RESET;
            r_pll_rst <= 1'b1;
            r_dom     <= '0;
            r_ready   <= 1'b0;
            r_hold    <= '0;
            r_stag    <= '0;
            r_loss    <= '0;
          end else begin
            r_loss <= w_lock_s ? '0 : r_loss + 1'b1;
            if (r_state == ST_RELEASE) begin
              if (r_stag == STAG_LAST) begin
                r_stag <= '0;
                r_dom  <= w_dom_shift;
                if (r_dom[NUM_DOMAINS-2]) begin
                  r_state <= ST_RUN;
                  r_ready <= 1'b1;
                  r_retry <= '0;
                end
              end else begin
                r_stag <= r_stag + 1'b1;
              end
            end
          end
        end

        ST_FAIL: begin
          r_fail    <= 1'b1;
          r_pll_rst <= 1'b0;
          r_dom     <= '0;
          r_ready   <= 1'b0;
        end

        default: begin
          r_state   <= ST_RESET;
          r_pll_rst <= 1'b1;
          r_dom     <= '0;
          r_ready   <= 1'b0;
          r_hold    <= '0;
        end
      endcase
    end
  end

  assign pll_rst      = r_pll_rst;
  assign domain_rst_n = r_dom;
  assign ready        = r_ready;
  assign fail         = r_fail;
  assign retry_cnt    = r_retry;
  assign state        = r_state;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq with small timing parameters.
// Cycle n is the interval after the n-th rising edge following rst_n release;
// outputs are sampled 1 time unit after each rising edge.
module tb_pll_reset_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       req_reset = 1'b0;
  logic       pll_rst;
  logic [3:0] domain_rst_n;
  logic       ready;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  pll_reset_seq #(
    .NUM_DOMAINS  (4),
    .RST_HOLD     (4),
    .LOCK_TIMEOUT (100),
    .LOCK_STABLE  (8),
    .STAGGER      (2),
    .LOSS_FILTER  (3),
    .MAX_RETRIES  (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .req_reset    (req_reset),
    .pll_rst      (pll_rst),
    .domain_rst_n (domain_rst_n),
    .ready        (ready),
    .fail         (fail),
    .retry_cnt    (retry_cnt),
    .state        (state)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    // held in reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_dom", 32'(domain_rst_n), 'h0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_retry", 32'(retry_cnt), 0);
    chk("rst_state", 32'(state), 0);

    // clean bring-up
    rst_n = 1'b1;
    cyc = 0;
    chk("up_pll_rst_c0", 32'(pll_rst), 1);
    go(3);
    chk("up_pll_rst_c3", 32'(pll_rst), 1);
    chk("up_state_c3", 32'(state), 0);
    go(4);
    chk("up_pll_rst_c4", 32'(pll_rst), 0);
    chk("up_state_c4", 32'(state), 1);
    go(20);
    pll_locked = 1'b1;
    go(22);
    chk("up_state_c22", 32'(state), 1);
    go(23);
    chk("up_state_c23", 32'(state), 2);
    go(30);
    chk("up_dom_c30", 32'(domain_rst_n), 'h0);
    go(31);
    chk("up_dom_c31", 32'(domain_rst_n), 'h1);
    chk("up_state_c31", 32'(state), 3);
    go(32);
    chk("up_dom_c32", 32'(domain_rst_n), 'h1);
    go(33);
    chk("up_dom_c33", 32'(domain_rst_n), 'h3);
    go(35);
    chk("up_dom_c35", 32'(domain_rst_n), 'h7);
    go(36);
    chk("up_ready_c36", 32'(ready), 0);
    go(37);
    chk("up_dom_c37", 32'(domain_rst_n), 'hF);
    chk("up_ready_c37", 32'(ready), 1);
    chk("up_state_c37", 32'(state), 4);
    chk("up_retry_c37", 32'(retry_cnt), 0);

    // short dropout in RUN is filtered
    go(50);
    pll_locked = 1'b0;
    go(52);
    pll_locked = 1'b1;
    go(60);
    chk("short_state", 32'(state), 4);
    chk("short_dom", 32'(domain_rst_n), 'hF);
    chk("short_ready", 32'(ready), 1);

    // 3-cycle dropout trips the filter: lock_s low in cycles 72..74
    go(70);
    pll_locked = 1'b0;
    go(73);
    pll_locked = 1'b1;
    go(74);
    chk("loss_state_c74", 32'(state), 4);
    chk("loss_ready_c74", 32'(ready), 1);
    go(75);
    chk("loss_dom_c75", 32'(domain_rst_n), 'h0);
    chk("loss_ready_c75", 32'(ready), 0);
    chk("loss_state_c75", 32'(state), 0);
    chk("loss_pll_rst_c75", 32'(pll_rst), 1);
    chk("loss_retry_c75", 32'(retry_cnt), 0);
    go(79);
    chk("relock_state_c79", 32'(state), 1);
    go(80);
    chk("relock_state_c80", 32'(state), 2);

    // STABLE glitch: lock_s low in cycle 85 only
    go(83);
    pll_locked = 1'b0;
    go(84);
    pll_locked = 1'b1;
    chk("glitch_state_c84", 32'(state), 2);
    go(86);
    chk("glitch_state_c86", 32'(state), 1);
    chk("glitch_pll_rst_c86", 32'(pll_rst), 0);
    go(88);
    chk("glitch_dom_c88", 32'(domain_rst_n), 'h0);
    go(94);
    chk("glitch_dom_c94", 32'(domain_rst_n), 'h0);
    chk("glitch_pll_rst_c94", 32'(pll_rst), 0);
    go(95);
    chk("glitch_dom_c95", 32'(domain_rst_n), 'h1);
    go(101);
    chk("glitch_ready_c101", 32'(ready), 1);
    chk("glitch_dom_c101", 32'(domain_rst_n), 'hF);

    // req_reset in RUN, then lock never returns: three timeouts
    go(110);
    req_reset = 1'b1;
    pll_locked = 1'b0;
    go(111);
    req_reset = 1'b0;
    chk("req_state_c111", 32'(state), 0);
    chk("req_ready_c111", 32'(ready), 0);
    chk("req_dom_c111", 32'(domain_rst_n), 'h0);
    go(114);
    chk("req_pll_rst_c114", 32'(pll_rst), 1);
    go(115);
    chk("req_state_c115", 32'(state), 1);
    go(214);
    chk("to1_state_c214", 32'(state), 1);
    chk("to1_retry_c214", 32'(retry_cnt), 0);
    go(215);
    chk("to1_state_c215", 32'(state), 0);
    chk("to1_retry_c215", 32'(retry_cnt), 1);
    chk("to1_pll_rst_c215", 32'(pll_rst), 1);
    go(218);
    chk("to1_pll_rst_c218", 32'(pll_rst), 1);
    go(219);
    chk("to1_pll_rst_c219", 32'(pll_rst), 0);
    go(319);
    chk("to2_retry_c319", 32'(retry_cnt), 2);
    chk("to2_state_c319", 32'(state), 0);
    go(422);
    chk("to3_fail_c422", 32'(fail), 0);
    go(423);
    chk("to3_fail_c423", 32'(fail), 1);
    chk("to3_state_c423", 32'(state), 5);
    chk("to3_retry_c423", 32'(retry_cnt), 3);
    chk("to3_pll_rst_c423", 32'(pll_rst), 0);
    go(430);
    chk("fail_hold_state", 32'(state), 5);
    chk("fail_hold_dom", 32'(domain_rst_n), 'h0);

    // recovery from FAIL with a one-cycle req_reset
    go(440);
    req_reset = 1'b1;
    pll_locked = 1'b1;
    go(441);
    req_reset = 1'b0;
    chk("rec_fail_c441", 32'(fail), 0);
    chk("rec_retry_c441", 32'(retry_cnt), 0);
    chk("rec_state_c441", 32'(state), 0);
    chk("rec_pll_rst_c441", 32'(pll_rst), 1);
    go(444);
    chk("rec_state_c444", 32'(state), 0);
    go(445);
    chk("rec_state_c445", 32'(state), 1);
    chk("rec_pll_rst_c445", 32'(pll_rst), 0);
    go(454);
    chk("rec_dom_c454", 32'(domain_rst_n), 'h1);
    go(456);
    chk("rec_dom_c456", 32'(domain_rst_n), 'h3);
    chk("rec_state_c456", 32'(state), 3);

    // async reset mid-RELEASE, between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_dom", 32'(domain_rst_n), 'h0);
    chk("arst_pll_rst", 32'(pll_rst), 1);
    chk("arst_state", 32'(state), 0);
    chk("arst_ready", 32'(ready), 0);
    chk("arst_retry", 32'(retry_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
